// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receive frame controller.
// Optional input synchronizer is selected with UART_RX_SYNC_EN.
package uart_rx_pkg;

    localparam int MAX_DATA_WIDTH = 9;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    // Unused upper bits are zero, so they never disturb the XOR.
    function automatic logic expected_parity(
        input logic [MAX_DATA_WIDTH-1:0] data,
        input logic                      typ
    );
        return (^data) ^ typ;
    endfunction

endpackage

// File: rtl/uart_rx_frame_ctrl_sampler.sv
// 3-tap majority sampler: holds taps at M-1 and M, votes with the
// live line at M+1.
module uart_rx_sampler #(
    parameter int OVERSAMPLE = 8,
    localparam int EW = $clog2(OVERSAMPLE)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [EW-1:0] edge_cnt,
    input  logic          rx,
    output logic          majority
);

    localparam logic [EW-1:0] TAP0 = EW'(OVERSAMPLE / 2 - 1);
    localparam logic [EW-1:0] TAP1 = EW'(OVERSAMPLE / 2);

    logic s0;
    logic s1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0 <= 1'b0;
            s1 <= 1'b0;
        end else begin
            if (edge_cnt == TAP0) s0 <= rx;
            if (edge_cnt == TAP1) s1 <= rx;
        end
    end

    assign majority = (s0 & s1) | (s0 & rx) | (s1 & rx);

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: start/data/parity/stop FSM.
// Define UART_RX_SYNC_EN to add a 2-flop synchronizer on RX_IN.
module uart_rx_frame_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX_IN,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stop_err,
    output logic                  busy
);

    localparam int EW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [EW-1:0] DEC  = EW'(OVERSAMPLE / 2 + 1);
    localparam logic [EW-1:0] LAST = EW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] NBITS = BW'(DATA_WIDTH);

    rx_state_t             state;
    logic [EW-1:0]         edge_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [BW-1:0]         bit_next;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic                  par_bad;
    logic                  rx;
    logic                  maj;
    logic                  at_dec;
    logic                  at_last;
    logic [MAX_DATA_WIDTH-1:0] pad;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= 2'b11;
        else     sync_q <= {sync_q[0], RX_IN};
    end

    assign rx = sync_q[1];
`else
    assign rx = RX_IN;
`endif

    uart_rx_sampler #(
        .OVERSAMPLE(OVERSAMPLE)
    ) u_sampler (
        .clk      (clk),
        .rst      (rst),
        .edge_cnt (edge_cnt),
        .rx       (rx),
        .majority (maj)
    );

    assign at_dec   = (edge_cnt == DEC);
    assign at_last  = (edge_cnt == LAST);
    // With OVERSAMPLE=4 the decision and the last edge coincide.
    assign bit_next = at_dec ? bit_cnt + 1'b1 : bit_cnt;

    always_comb begin
        pad = '0;
        pad[DATA_WIDTH-1:0] = shreg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= PAR_EVEN;
            par_bad    <= 1'b0;
            P_DATA     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stop_err   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stop_err   <= 1'b0;
            if (state != ST_IDLE)
                edge_cnt <= at_last ? '0 : edge_cnt + 1'b1;
            unique case (state)
                ST_IDLE: begin
                    if (!rx) begin
                        state     <= ST_START;
                        edge_cnt  <= EW'(1);
                        par_en_q  <= par_en;
                        par_typ_q <= par_typ;
                        par_bad   <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                ST_START: begin
                    if (at_dec && maj) begin
                        state    <= ST_IDLE;
                        edge_cnt <= '0;
                        busy     <= 1'b0;
                    end else if (at_last) begin
                        state   <= ST_DATA;
                        bit_cnt <= '0;
                    end
                end
                ST_DATA: begin
                    // LSB arrives first and ends up in bit 0.
                    if (at_dec) begin
                        shreg   <= {maj, shreg[DATA_WIDTH-1:1]};
                        bit_cnt <= bit_next;
                    end
                    if (at_last && bit_next == NBITS)
                        state <= par_en_q ? ST_PARITY : ST_STOP;
                end
                ST_PARITY: begin
                    if (at_dec)
                        par_bad <= maj != expected_parity(pad, par_typ_q);
                    if (at_last)
                        state <= ST_STOP;
                end
                ST_STOP: begin
                    if (at_dec) begin
                        state    <= ST_IDLE;
                        edge_cnt <= '0;
                        busy     <= 1'b0;
                        stop_err <= ~maj;
                        par_err  <= par_bad;
                        if (maj && !par_bad) begin
                            P_DATA     <= shreg;
                            data_valid <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl (8 data bits, 8x oversampling).
module tb_uart_rx_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       RX_IN = 1'b1;
    logic       par_en = 1'b0;
    logic       par_typ = 1'b0;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       par_err;
    logic       stop_err;
    logic       busy;

    int checks = 0;
    int errors = 0;

    uart_rx_frame_ctrl #(
        .DATA_WIDTH(8),
        .OVERSAMPLE(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .RX_IN      (RX_IN),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .P_DATA     (P_DATA),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stop_err   (stop_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic line_bit(input int c, input logic [7:0] d,
                                      input bit pon, input bit pbit,
                                      input bit sbit);
        int b;
        b = c / 8;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (pon && b == 9) return pbit;
        if (b == 9 + int'(pon)) return sbit;
        return 1'b1;
    endfunction

    // Cycle c of the frame: sample outputs of cycle c, drive line of cycle c.
    task automatic drive_frame(input logic [7:0] d, input bit pon,
                               input bit ptyp, input bit pbit,
                               input bit sbit, input int ncyc,
                               output int dv_n, output int dv_at,
                               output int pe_n, output int pe_at,
                               output int se_n, output int se_at);
        dv_n = 0; dv_at = -1;
        pe_n = 0; pe_at = -1;
        se_n = 0; se_at = -1;
        for (int c = 0; c < ncyc; c++) begin
            if (data_valid) begin dv_n++; if (dv_at < 0) dv_at = c; end
            if (par_err)    begin pe_n++; if (pe_at < 0) pe_at = c; end
            if (stop_err)   begin se_n++; if (se_at < 0) se_at = c; end
            RX_IN = line_bit(c, d, pon, pbit, sbit);
            if (c == 0) begin
                par_en  = pon;
                par_typ = ptyp;
            end else if (c == 1) begin
                par_en  = ~pon;
                par_typ = ~ptyp;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        RX_IN = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({P_DATA, data_valid, par_err, stop_err, busy} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs got %h want 000",
                     {P_DATA, data_valid, par_err, stop_err, busy});
        end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_frame_a5();
        int dn, da, pn, pa, sn, sa;
        drive_frame(8'hA5, 0, 0, 0, 1, 100, dn, da, pn, pa, sn, sa);
        checks++;
        if (dn !== 1 || da !== 78) begin
            errors++;
            $display("FAIL a5_valid got n=%0d at=%0d want n=1 at=78", dn, da);
        end
        checks++;
        if (P_DATA !== 8'hA5) begin
            errors++;
            $display("FAIL a5_data got %h want a5", P_DATA);
        end
        checks++;
        if (pn !== 0 || sn !== 0) begin
            errors++;
            $display("FAIL a5_errs got pe=%0d se=%0d want 0 0", pn, sn);
        end
    endtask

    task automatic test_glitch();
        int b1, low_at, pulses;
        b1 = 0; low_at = -1; pulses = 0;
        for (int c = 0; c < 40; c++) begin
            if (c == 1) b1 = busy;
            if (c >= 1 && !busy && low_at < 0) low_at = c;
            if (data_valid || par_err || stop_err) pulses++;
            RX_IN = (c < 2) ? 1'b0 : 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (b1 !== 1) begin
            errors++;
            $display("FAIL glitch_busy got %0d want 1", b1);
        end
        checks++;
        if (low_at < 0 || low_at > 6) begin
            errors++;
            $display("FAIL glitch_idle got cycle %0d want <=6", low_at);
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL glitch_pulses got %0d want 0", pulses);
        end
    endtask

    task automatic test_parity_err();
        int dn, da, pn, pa, sn, sa;
        drive_frame(8'h37, 1, 0, 0, 1, 100, dn, da, pn, pa, sn, sa);
        checks++;
        if (pn !== 1 || pa !== 86) begin
            errors++;
            $display("FAIL par_err got n=%0d at=%0d want n=1 at=86", pn, pa);
        end
        checks++;
        if (dn !== 0 || sn !== 0) begin
            errors++;
            $display("FAIL par_other got dv=%0d se=%0d want 0 0", dn, sn);
        end
        checks++;
        if (P_DATA !== 8'hA5) begin
            errors++;
            $display("FAIL par_hold got %h want a5", P_DATA);
        end
    endtask

    task automatic test_parity_ok();
        int dn, da, pn, pa, sn, sa;
        drive_frame(8'h37, 1, 1, 0, 1, 100, dn, da, pn, pa, sn, sa);
        checks++;
        if (dn !== 1 || da !== 86 || pn !== 0) begin
            errors++;
            $display("FAIL odd_ok got dv=%0d at=%0d pe=%0d want 1 86 0",
                     dn, da, pn);
        end
        checks++;
        if (P_DATA !== 8'h37) begin
            errors++;
            $display("FAIL odd_data got %h want 37", P_DATA);
        end
    endtask

    task automatic test_stop_err();
        int dn, da, pn, pa, sn, sa;
        drive_frame(8'h5A, 0, 0, 0, 0, 100, dn, da, pn, pa, sn, sa);
        checks++;
        if (sn !== 1 || sa !== 78) begin
            errors++;
            $display("FAIL stop_err got n=%0d at=%0d want n=1 at=78", sn, sa);
        end
        checks++;
        if (dn !== 0 || pn !== 0 || P_DATA !== 8'h37) begin
            errors++;
            $display("FAIL stop_hold got dv=%0d pe=%0d data=%h want 0 0 37",
                     dn, pn, P_DATA);
        end
    endtask

    task automatic test_back_to_back();
        int dn, da, pn, pa, sn, sa;
        drive_frame(8'h00, 0, 0, 0, 1, 80, dn, da, pn, pa, sn, sa);
        checks++;
        if (dn !== 1 || da !== 78 || P_DATA !== 8'h00) begin
            errors++;
            $display("FAIL b2b_first got n=%0d at=%0d data=%h want 1 78 00",
                     dn, da, P_DATA);
        end
        drive_frame(8'hFF, 0, 0, 0, 1, 100, dn, da, pn, pa, sn, sa);
        checks++;
        if (dn !== 1 || da !== 78 || P_DATA !== 8'hFF) begin
            errors++;
            $display("FAIL b2b_second got n=%0d at=%0d data=%h want 1 78 ff",
                     dn, da, P_DATA);
        end
    endtask

    task automatic test_reset_mid();
        int dn, da, pn, pa, sn, sa;
        int b_pre;
        b_pre = 0;
        for (int c = 0; c < 36; c++) begin
            if (c == 35) b_pre = busy;
            RX_IN = line_bit(c, 8'hC3, 0, 0, 1);
            par_en = 1'b0;
            if (c < 35) begin
                @(posedge clk); #1;
            end
        end
        checks++;
        if (b_pre !== 1) begin
            errors++;
            $display("FAIL mid_busy got %0d want 1", b_pre);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({P_DATA, data_valid, par_err, stop_err, busy} !== 12'h000) begin
            errors++;
            $display("FAIL mid_reset got %h want 000",
                     {P_DATA, data_valid, par_err, stop_err, busy});
        end
        @(posedge clk); #1;
        RX_IN = 1'b1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        drive_frame(8'hC3, 0, 0, 0, 1, 100, dn, da, pn, pa, sn, sa);
        checks++;
        if (dn !== 1 || da !== 78 || P_DATA !== 8'hC3) begin
            errors++;
            $display("FAIL mid_after got n=%0d at=%0d data=%h want 1 78 c3",
                     dn, da, P_DATA);
        end
    endtask

    initial begin
        test_reset();
        test_frame_a5();
        test_glitch();
        test_parity_err();
        test_parity_ok();
        test_stop_err();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
